// File: rtl/fft_stage_sequencer_pkg.sv
// Shared FFT sequencer parameters: FSM state encoding, default pass count and field widths.
package fft_stage_sequencer_pkg;

    localparam int unsigned NPASS_DEF = 3;
    localparam int unsigned STAGE_W   = 2;
    localparam int unsigned FRAMES_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/fft_seq_wdog.sv
// RUN-state watchdog: counts cycles spent in RUN and flags when the budget is exhausted.
module fft_seq_wdog
    import fft_stage_sequencer_pkg::*;
#(
    parameter int unsigned WDOG_CYC = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic run_i,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(WDOG_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of RUN cycles already completed
    assign expired_c = run_i && (cnt_q == CNT_W'(WDOG_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (run_i && !expired_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Sequences the butterfly passes of one 32-point FFT frame and decodes per-pass controls.
// Optional RUN watchdog enabled by defining FFT_SEQ_WDOG_EN.
module fft_stage_sequencer
    import fft_stage_sequencer_pkg::*;
#(
    parameter int unsigned NPASS    = NPASS_DEF,
    parameter int unsigned WDOG_CYC = 1023
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic                BUF_RDY,
    input  logic                PASS_DONE,
    output logic                PASS_START,
    output logic [STAGE_W-1:0]  STAGE,
    output logic                WSTAGE,
    output logic                GEMM_CTRL,
    output logic                TW_EN,
    output logic                INV_ADDR,
    output logic                BUSY,
    output logic                RDY,
    output logic                ERR,
    output logic [FRAMES_W-1:0] FRAMES
);

    seq_state_e          state_q, state_d;
    logic [STAGE_W-1:0]  stage_q, stage_d;
    logic [FRAMES_W-1:0] frames_q, frames_d;
    logic                err_q, err_d;
    logic                pass_start_q, pass_start_d;
    logic                wstage_q, wstage_d;
    logic                gemm_q, gemm_d;
    logic                tw_en_q, tw_en_d;
    logic                inv_q, inv_d;
    logic                busy_q, busy_d;
    logic                rdy_q, rdy_d;
    logic                last_pass_c;
    logic                wdog_expired_c;

    assign last_pass_c = (stage_q == STAGE_W'(NPASS - 1));

`ifdef FFT_SEQ_WDOG_EN
    fft_seq_wdog #(
        .WDOG_CYC (WDOG_CYC)
    ) u_wdog (
        .clk       (CLK),
        .rst_n     (RST),
        .clr_i     (state_q == ST_ISSUE),
        .run_i     (state_q == ST_RUN),
        .expired_c (wdog_expired_c)
    );
`else
    // WDOG_CYC has no effect in this build; referenced so both builds share one interface
    assign wdog_expired_c = 1'b0 & (WDOG_CYC == 32'd0);
`endif

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        frames_d = frames_q;
        err_d    = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_LOAD;
                    stage_d = '0;
                end
            end
            ST_LOAD: begin
                if (BUF_RDY) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (PASS_DONE) begin
                    if (last_pass_c) begin
                        state_d  = ST_DONE;
                        frames_d = frames_q + FRAMES_W'(1);
                    end else begin
                        state_d = ST_LOAD;
                        stage_d = stage_q + STAGE_W'(1);
                    end
                end else if (wdog_expired_c) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // a START that cannot be accepted is a protocol error; the frame continues
        if (START && (state_q != ST_IDLE)) begin
            err_d = 1'b1;
        end

        busy_d       = (state_d != ST_IDLE);
        pass_start_d = (state_d == ST_ISSUE);
        rdy_d        = (state_d == ST_DONE);
        wstage_d     = busy_d && stage_d[0];
        gemm_d       = busy_d && (stage_d != STAGE_W'(NPASS - 1));
        tw_en_d      = gemm_d;
        inv_d        = busy_d && (stage_d == STAGE_W'(1));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            stage_q      <= '0;
            frames_q     <= '0;
            err_q        <= 1'b0;
            pass_start_q <= 1'b0;
            wstage_q     <= 1'b0;
            gemm_q       <= 1'b0;
            tw_en_q      <= 1'b0;
            inv_q        <= 1'b0;
            busy_q       <= 1'b0;
            rdy_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            frames_q     <= frames_d;
            err_q        <= err_d;
            pass_start_q <= pass_start_d;
            wstage_q     <= wstage_d;
            gemm_q       <= gemm_d;
            tw_en_q      <= tw_en_d;
            inv_q        <= inv_d;
            busy_q       <= busy_d;
            rdy_q        <= rdy_d;
        end
    end

    assign PASS_START = pass_start_q;
    assign STAGE      = stage_q;
    assign WSTAGE     = wstage_q;
    assign GEMM_CTRL  = gemm_q;
    assign TW_EN      = tw_en_q;
    assign INV_ADDR   = inv_q;
    assign BUSY       = busy_q;
    assign RDY        = rdy_q;
    assign ERR        = err_q;
    assign FRAMES     = frames_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Randomized frame-level bench for fft_stage_sequencer against a pass/frame/error reference model.
module tb_fft_stage_sequencer;

    localparam int NP = 3;
`ifdef FFT_SEQ_WDOG_EN
    localparam int WD = 16;
`else
    localparam int WD = 1023;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       buf_rdy = 1'b0;
    logic       pass_done = 1'b0;
    logic       pass_start, wstage, gemm, tw_en, inv, busy, rdy, err;
    logic [1:0] stage;
    logic [7:0] frames;

    fft_stage_sequencer #(
        .NPASS    (NP),
        .WDOG_CYC (WD)
    ) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .START      (start),
        .BUF_RDY    (buf_rdy),
        .PASS_DONE  (pass_done),
        .PASS_START (pass_start),
        .STAGE      (stage),
        .WSTAGE     (wstage),
        .GEMM_CTRL  (gemm),
        .TW_EN      (tw_en),
        .INV_ADDR   (inv),
        .BUSY       (busy),
        .RDY        (rdy),
        .ERR        (err),
        .FRAMES     (frames)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int rdy_seen = 0;
    int ps_seen  = 0;

    // reference model state
    int exp_frames = 0;
    int exp_err    = 0;

    always @(posedge clk) begin
        if (rdy === 1'b1) rdy_seen++;
        if (pass_start === 1'b1) ps_seen++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    function automatic int m_gemm(input int p);
        return (p != NP - 1) ? 1 : 0;
    endfunction

    task automatic chk_decode(input string tag, input int p);
        check({tag, "_stage"}, int'(stage), p);
        check({tag, "_wstage"}, int'(wstage), p % 2);
        check({tag, "_gemm"}, int'(gemm), m_gemm(p));
        check({tag, "_tw_en"}, int'(tw_en), m_gemm(p));
        check({tag, "_inv"}, int'(inv), (p == 1) ? 1 : 0);
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_pstart"}, int'(pass_start), 0);
        check({tag, "_wstage"}, int'(wstage), 0);
        check({tag, "_gemm"}, int'(gemm), 0);
        check({tag, "_tw_en"}, int'(tw_en), 0);
        check({tag, "_inv"}, int'(inv), 0);
        check({tag, "_rdy"}, int'(rdy), 0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk_idle(tag);
        check({tag, "_stage"}, int'(stage), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_frames"}, int'(frames), 0);
        tick_n(2);
        rst_n = 1'b1;
        exp_err    = 0;
        exp_frames = 0;
        tick();
        check({tag, "_post_busy"}, int'(busy), 0);
    endtask

    // one full frame; busy_pass >= 0 injects a START during that pass's RUN
    task automatic run_frame(input int first_gap, input bit spur, input int busy_pass, input bit coincide);
        int rdy0 = rdy_seen;
        int ps0  = ps_seen;
        int gap;
        start = 1'b1; tick(); start = 1'b0;
        check("start_busy", int'(busy), 1);
        chk_decode("load0", 0);
        for (int p = 0; p < NP; p++) begin
            gap = (p == 0) ? first_gap : int'($urandom_range(0, 4));
            for (int g = 0; g < gap; g++) begin
                if (spur && $urandom_range(0, 1) == 1) pass_done = 1'b1;
                tick();
                pass_done = 1'b0;
            end
            check("load_no_issue", int'(pass_start), 0);
            check("load_stage", int'(stage), p);
            check("load_err", int'(err), exp_err);
            buf_rdy = 1'b1; tick(); buf_rdy = 1'b0;
            check("issue_pstart", int'(pass_start), 1);
            chk_decode("issue", p);
            tick();
            check("run_pstart", int'(pass_start), 0);
            check("run_busy", int'(busy), 1);
            gap = int'($urandom_range(0, 4));
            for (int g = 0; g < gap; g++) begin
                if (spur && $urandom_range(0, 1) == 1) buf_rdy = 1'b1;
                tick();
                buf_rdy = 1'b0;
                check("run_spur_pstart", int'(pass_start), 0);
            end
            if (p == busy_pass) begin
                start = 1'b1; tick(); start = 1'b0;
                exp_err = 1;
                check("busy_start_err", int'(err), 1);
                check("busy_start_stage", int'(stage), p);
                check("busy_start_busy", int'(busy), 1);
            end
            pass_done = 1'b1;
            if (coincide && p == NP - 1) begin
                start   = 1'b1;
                exp_err = 1;
            end
            tick();
            pass_done = 1'b0;
            start     = 1'b0;
            if (p == NP - 1) begin
                check("done_rdy", int'(rdy), 1);
                check("done_busy", int'(busy), 1);
                exp_frames = (exp_frames + 1) % 256;
                tick();
                chk_idle("post_frame");
                check("frames", int'(frames), exp_frames);
            end else begin
                check("next_rdy", int'(rdy), 0);
                check("next_stage", int'(stage), p + 1);
                check("next_busy", int'(busy), 1);
            end
            check("err_model", int'(err), exp_err);
        end
        check("rdy_pulses", rdy_seen - rdy0, 1);
        check("pstart_pulses", ps_seen - ps0, NP);
    endtask

    task automatic run_stall();
        int rdy0 = rdy_seen;
        start = 1'b1; tick(); start = 1'b0;
        buf_rdy = 1'b1; tick(); buf_rdy = 1'b0;
        tick();
`ifdef FFT_SEQ_WDOG_EN
        tick_n(WD - 1);
        check("wdog_pre_busy", int'(busy), 1);
        check("wdog_pre_err", int'(err), 0);
        tick();
        check("wdog_err", int'(err), 1);
        chk_idle("wdog_idle");
        tick_n(3);
        check("wdog_no_rdy", rdy_seen - rdy0, 0);
`else
        tick_n(60);
        check("stall_busy", int'(busy), 1);
        check("stall_err", int'(err), 0);
        check("stall_stage", int'(stage), 0);
        check("stall_no_rdy", rdy_seen - rdy0, 0);
`endif
        do_reset("stall_rst");
    endtask

    initial begin
        int rdy0;
        tick_n(2);
        chk_idle("por");
        check("por_err", int'(err), 0);
        check("por_frames", int'(frames), 0);
        check("por_stage", int'(stage), 0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", int'(busy), 0);

        // nominal frame with spurious PASS_DONE in LOAD and BUF_RDY in RUN
        run_frame(40, 1'b1, -1, 1'b0);
        check("nominal_frames", int'(frames), 1);
        check("nominal_err", int'(err), 0);

        run_stall();

        for (int i = 0; i < 4; i++) begin
            run_frame(int'($urandom_range(0, 6)), 1'b1, 1, 1'b0);
        end
        check("busy_start_frames", int'(frames), 4);

        run_frame(int'($urandom_range(0, 6)), 1'b0, -1, 1'b1);
        check("coincide_frames", int'(frames), 5);

        // reset during RUN of pass 1
        rdy0 = rdy_seen;
        start = 1'b1; tick(); start = 1'b0;
        buf_rdy = 1'b1; tick(); buf_rdy = 1'b0;
        tick();
        pass_done = 1'b1; tick(); pass_done = 1'b0;
        buf_rdy = 1'b1; tick(); buf_rdy = 1'b0;
        tick();
        check("midrst_stage_pre", int'(stage), 1);
        do_reset("midrst");
        tick_n(3);
        check("midrst_no_rdy", rdy_seen - rdy0, 0);
        run_frame(int'($urandom_range(0, 6)), 1'b1, -1, 1'b0);
        check("midrst_clean_frames", int'(frames), 1);
        check("midrst_clean_err", int'(err), 0);

        // FRAMES wrap over 256 frames
        do_reset("wrap_rst");
        rdy0 = rdy_seen;
        for (int i = 0; i < 256; i++) begin
            run_frame(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1, 1'b0);
        end
        check("wrap_frames", int'(frames), 0);
        check("wrap_rdy_count", rdy_seen - rdy0, 256);
        check("wrap_err", int'(err), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 SHALL have parameter NPASS, default 3, meaning number of butterfly passes per 32-point frame.
REQ-002 SHALL have parameter WDOG_CYC, default 1023, meaning maximum cycles allowed in RUN before abort (used only with FFT_SEQ_WDOG_EN).
REQ-003 SHALL have ports:
  - CLK  in  1  clock
  - RST  in  1  reset; one clock, asynchronous, active-low
  - START  in  1  frame-start pulse
  - BUF_RDY  in  1  buffer-RAM frame-ready pulse
  - PASS_DONE  in  1  datapath-tail done pulse for the current pass
  - PASS_START  out  1  one-cycle start to serial-to-parallel stage
  - STAGE  out  2  current pass index
  - WSTAGE  out  1  twiddle-ROM stage select
  - GEMM_CTRL  out  1  1 = radix-4 pass, 0 = final radix-2 pass
  - TW_EN  out  1  twiddle multiply enable
  - INV_ADDR  out  1  buffer address-inversion select
  - BUSY  out  1  frame in flight
  - RDY  out  1  one-cycle frame-complete pulse
  - ERR  out  1  sticky protocol/watchdog error
  - FRAMES  out  8  completed-frame count

Function
REQ-004 SHALL implement FSM states IDLE, LOAD, ISSUE, RUN, DONE; all outputs registered.
REQ-005 SHALL transition IDLE->LOAD on START; STAGE cleared to 0 on that edge.
REQ-006 SHALL transition LOAD->ISSUE on BUF_RDY; other inputs are ignored in LOAD.
REQ-007 SHALL assert PASS_START for exactly the one cycle spent in ISSUE, then enter RUN; PASS_START is high the cycle after BUF_RDY is sampled.
REQ-008 SHALL, in RUN on PASS_DONE, act as follows:
  - STAGE < NPASS-1: increment STAGE, return to LOAD.
  - STAGE == NPASS-1: enter DONE.
REQ-009 SHALL, in DONE, assert RDY for one cycle, increment FRAMES (wrap 255->0), and return to IDLE.
REQ-010 SHALL decode outputs from STAGE whenever BUSY:
  - WSTAGE = STAGE[0].
  - GEMM_CTRL = (STAGE != NPASS-1).
  - TW_EN = GEMM_CTRL.
  - INV_ADDR = (STAGE == 1).
  - All four are 0 in IDLE.
REQ-011 SHALL hold BUSY high in LOAD, ISSUE, RUN and DONE, and low in IDLE.
REQ-012 SHALL, when START arrives while BUSY, ignore the pulse, set ERR, and leave the frame in flight undisturbed.
REQ-013 SHALL ignore PASS_DONE outside RUN and BUF_RDY outside LOAD; no state change, no ERR.
REQ-014 SHALL, when PASS_DONE and START coincide in RUN on the last pass, complete the frame normally and set ERR.
REQ-015 SHALL keep ERR set until reset.

Reset
REQ-016 SHALL, on RST low, asynchronously force:
  - State IDLE.
  - STAGE, PASS_START, WSTAGE, GEMM_CTRL, TW_EN, INV_ADDR, BUSY, RDY, ERR = 0.
  - FRAMES = 0.
REQ-017 SHALL, on reset asserted mid-frame, abandon the frame with no RDY pulse; operation resumes from IDLE on the first START after release.

Configuration
REQ-018 SHALL include a RUN-state watchdog only when FFT_SEQ_WDOG_EN is defined:
  - A cycle counter clears on entry to RUN.
  - When the counter reaches WDOG_CYC without PASS_DONE, the block sets ERR and goes to IDLE without RDY.
REQ-019 SHALL, without FFT_SEQ_WDOG_EN, wait in RUN indefinitely, with no counter logic present.

Structure
REQ-020 SHALL take from the shared FFT parameter package:
  - FSM state encoding.
  - Pass-count constant (3).
  - Stage-index width (2).
REQ-021 SHALL place the watchdog counter in sub-module fft_seq_wdog, instantiated only under FFT_SEQ_WDOG_EN.

Verification
REQ-022 SHALL cover a nominal frame:
  - Stimulus: START; BUF_RDY 40 cycles later; PASS_DONE per pass; repeated for 3 passes.
  - Response: 3 PASS_START pulses with STAGE 0,1,2.
  - Response: GEMM_CTRL 1,1,0; WSTAGE 0,1,0; INV_ADDR 0,1,0.
  - Response: one RDY; FRAMES=1.
REQ-023 SHALL cover START while BUSY:
  - Stimulus: START during pass 1.
  - Response: ERR=1; frame completes; FRAMES increments by 1 only.
REQ-024 SHALL cover a spurious PASS_DONE:
  - Stimulus: PASS_DONE while in LOAD.
  - Response: no state change; ERR stays 0.
REQ-025 SHALL cover reset mid-frame:
  - Stimulus: RST low for 2 cycles during RUN of pass 1.
  - Response: all outputs 0 immediately; no RDY; next START runs a clean frame.
REQ-026 SHALL cover the watchdog, with FFT_SEQ_WDOG_EN defined and WDOG_CYC=16:
  - Stimulus: withhold PASS_DONE.
  - Response: ERR=1 after 16 RUN cycles; state returns to IDLE; BUSY=0.
REQ-027 SHALL cover FRAMES wrap:
  - Stimulus: 256 back-to-back frames.
  - Response: FRAMES returns to 0 with 256 RDY pulses.
